mux4_to_1: RTL and testbench
============================

// Module: mux4_to_1
// PURPOSE
//   4-to-1 selector with two select bits (select1 = MSB, select0 = LSB).
//   - out: purely combinational selected value; the primary output used by the ALU datapath.
//   - out_q: optional registered copy of out, for pipelined ALU result paths.
//   - Building block of the 32-bit ALU result/operand selection.
// PARAMETERS
//   WIDTH  1  bit width of each data input and of both outputs
// PORTS
//   clk      input   1      rising-edge clock; used by the registered path only
//   rst_n    input   1      asynchronous, active-low reset
//   en       input   1      load enable for out_q
//   input1   input   WIDTH  data selected when {select1,select0} = 2'b00
//   input2   input   WIDTH  data selected when {select1,select0} = 2'b01
//   input3   input   WIDTH  data selected when {select1,select0} = 2'b10
//   input4   input   WIDTH  data selected when {select1,select0} = 2'b11
//   select1  input   1      select MSB
//   select0  input   1      select LSB
//   out      output  WIDTH  combinational selected value
//   out_q    output  WIDTH  registered selected value
//   out_vld  output  1      high once out_q holds a loaded value
// BEHAVIOUR
//   - Interface: one clock (clk); reset rst_n is asynchronous and active-low.
//   - out selection, zero latency, independent of clk, rst_n and en:
//     - 00 -> input1
//     - 01 -> input2
//     - 10 -> input3
//     - 11 -> input4
//   - out updates in the same delta as any change on a data or select input; no glitch filtering.
//   - Unknown select (X/Z on either select bit): out = all-X. Never silently default to a valid input.
//   - Reset: rst_n low clears out_q to 0 and out_vld to 0 immediately, with no clock needed.
//     - out remains combinational and valid during reset.
//   - Registered path, clk rising edge with rst_n high:
//     - en = 1: out_q <= out, out_vld <= 1.
//     - en = 0: out_q and out_vld hold.
//   - out_q latency: 1 cycle after en is sampled high.
//   - out_vld stays 1 until the next reset.
//   - Reset asserted mid-operation overrides en; any pending load is lost.
//   - On rst_n deassertion, the first load happens on the first edge with en = 1.
//   - Inputs and select changing on the same clock edge: the value sampled into out_q is out as it
//     stood just before that edge (standard setup semantics).
//   - Width: all data paths are exactly WIDTH bits. No extension or truncation.
// TESTING
//   - Fixed inputs input1=0, input2=1, input3=1, input4=0; apply each select for 20 time units:
//     - sel 00 -> out=0
//     - sel 01 -> out=1
//     - sel 10 -> out=1
//     - sel 11 -> out=0
//   - Exhaustive: WIDTH=1, all 64 combinations of 4 inputs x 2 selects -> out equals the indexed input.
//   - WIDTH=8, inputs 8'hA5/8'h3C/8'hFF/8'h00, sweep selects -> out = A5, 3C, FF, 00 in order.
//   - Registered path: rst_n=0 -> out_q=0, out_vld=0 with no clock edge.
//     - Release reset, en=1, sel=01 -> next edge: out_q=input2, out_vld=1.
//     - en=0 while inputs change -> out_q holds.
//   - Drive rst_n low between clock edges while en=1 -> out_q=0 and out_vld=0 immediately.
//     - out continues to track the inputs throughout.
//   - select0 = X -> out = X.
//     - Restore select0 = 0 -> out returns to input1 (or input3 per select1) with zero delay.

Source files
------------

// File: rtl/mux4_to_1.sv
// 4-to-1 selector: zero-latency combinational output plus an optional
// registered copy with a sticky valid flag, used in the ALU result/operand paths.
module mux4_to_1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [WIDTH-1:0] input3,
  input  logic [WIDTH-1:0] input4,
  input  logic             select1,
  input  logic             select0,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_vld
);

  // NOTE: every path through this block assigns out, so no latch is inferred;
  // an X/Z select falls to the default and propagates X instead of picking an input.
  always_comb begin
    case ({select1, select0})
      2'b00:   out = input1;
      2'b01:   out = input2;
      2'b10:   out = input3;
      2'b11:   out = input4;
      default: out = 'x;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // its pre-edge value, which gives out_q the value out held just before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      out_vld <= 1'b0;
    end else if (en) begin
      out_q   <= out;
      out_vld <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux4_to_1.sv
// Self-checking bench for mux4_to_1: WIDTH=1 and WIDTH=8 instances driven in
// parallel, expected values queued in a scoreboard and compared at sample time.
module tb_mux4_to_1;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       select1;
  logic       select0;
  logic       a1, a2, a3, a4;
  logic       a_out, a_out_q, a_vld;
  logic [7:0] b1, b2, b3, b4;
  logic [7:0] b_out, b_out_q;
  logic       b_vld;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  mux4_to_1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .input1(a1), .input2(a2), .input3(a3), .input4(a4),
    .select1(select1), .select0(select0),
    .out(a_out), .out_q(a_out_q), .out_vld(a_vld)
  );

  mux4_to_1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .input1(b1), .input2(b2), .input3(b3), .input4(b4),
    .select1(select1), .select0(select0),
    .out(b_out), .out_q(b_out_q), .out_vld(b_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [7:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check(input logic [7:0] obs);
    if (exp_q.size() == 0) check("scoreboard_empty", obs, 8'hxx);
    else check(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask

  task automatic set_sel(input logic [1:0] s);
    select1 = s[1];
    select0 = s[0];
  endtask

  // Reference selection, written independently of the DUT.
  function automatic logic [7:0] pick8(input logic [1:0] s, input logic [7:0] x1,
                                       input logic [7:0] x2, input logic [7:0] x3,
                                       input logic [7:0] x4);
    if (s == 2'd0) return x1;
    if (s == 2'd1) return x2;
    if (s == 2'd2) return x3;
    return x4;
  endfunction

  initial begin
    rst_n = 1'b1; en = 1'b0; set_sel(2'b00);
    {a1, a2, a3, a4} = 4'b0;
    b1 = 8'h0; b2 = 8'h0; b3 = 8'h0; b4 = 8'h0;

    // Async reset before any clock edge (first posedge is at t=5).
    #1 rst_n = 1'b0;
    #1;
    expect_val("rst_out_q_w1", 8'h00); pop_check({7'b0, a_out_q});
    expect_val("rst_vld_w1",   8'h00); pop_check({7'b0, a_vld});
    expect_val("rst_out_q_w8", 8'h00); pop_check(b_out_q);
    expect_val("rst_vld_w8",   8'h00); pop_check({7'b0, b_vld});

    // Fixed-pattern sweep, each select held for 20 time units.
    a1 = 1'b0; a2 = 1'b1; a3 = 1'b1; a4 = 1'b0;
    begin
      logic [3:0] fixed_exp;
      fixed_exp = 4'b0110;
      for (int s = 0; s < 4; s++) begin
        set_sel(s[1:0]);
        expect_val($sformatf("fixed_sel%0d", s), {7'b0, fixed_exp[s]});
        #10 pop_check({7'b0, a_out});
        #10;
      end
    end

    // Exhaustive WIDTH=1: 4 data bits x 2 select bits.
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      v = i[5:0];
      {a4, a3, a2, a1} = v[3:0];
      set_sel(v[5:4]);
      expect_val($sformatf("exh_%0d", i),
                 pick8(v[5:4], {7'b0, v[0]}, {7'b0, v[1]}, {7'b0, v[2]}, {7'b0, v[3]}));
      #1 pop_check({7'b0, a_out});
    end

    // WIDTH=8 select sweep.
    b1 = 8'hA5; b2 = 8'h3C; b3 = 8'hFF; b4 = 8'h00;
    begin
      logic [7:0] sweep_exp [4];
      sweep_exp = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
      for (int s = 0; s < 4; s++) begin
        set_sel(s[1:0]);
        expect_val($sformatf("w8_sel%0d", s), sweep_exp[s]);
        #1 pop_check(b_out);
      end
    end

    // Still in reset across clock edges: registered outputs stay cleared.
    en = 1'b1;
    @(posedge clk); #1;
    expect_val("hold_in_rst_q", 8'h00);  pop_check(b_out_q);
    expect_val("hold_in_rst_v", 8'h00);  pop_check({7'b0, b_vld});

    // Release reset, load input2 on the next edge.
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; set_sel(2'b01);
    a1 = 1'b0; a2 = 1'b1; a3 = 1'b0; a4 = 1'b0;
    #1;
    expect_val("pre_load_vld", 8'h00); pop_check({7'b0, b_vld});
    @(posedge clk); #1;
    expect_val("load_q_w8", 8'h3C); pop_check(b_out_q);
    expect_val("load_v_w8", 8'h01); pop_check({7'b0, b_vld});
    expect_val("load_q_w1", 8'h01); pop_check({7'b0, a_out_q});

    // en=0: out_q holds while inputs and select change, out keeps tracking.
    @(negedge clk);
    en = 1'b0; b2 = 8'h77; set_sel(2'b10); b3 = 8'h5A;
    #1;
    expect_val("track_en0", 8'h5A); pop_check(b_out);
    repeat (3) @(posedge clk);
    #1;
    expect_val("hold_q_en0", 8'h3C); pop_check(b_out_q);
    expect_val("hold_v_en0", 8'h01); pop_check({7'b0, b_vld});

    // Second load with a different select.
    @(negedge clk);
    en = 1'b1; set_sel(2'b11); b4 = 8'hC3;
    @(posedge clk); #1;
    expect_val("load2_q", 8'hC3); pop_check(b_out_q);
    en = 1'b0;

    // Reset between edges while en=1: immediate clear, out still tracks.
    @(negedge clk);
    en = 1'b1; set_sel(2'b00); b1 = 8'h81;
    #2 rst_n = 1'b0;
    #1;
    expect_val("midrst_q", 8'h00); pop_check(b_out_q);
    expect_val("midrst_v", 8'h00); pop_check({7'b0, b_vld});
    expect_val("midrst_out", 8'h81); pop_check(b_out);
    b1 = 8'h42;
    #1;
    expect_val("midrst_track", 8'h42); pop_check(b_out);

    // Deassert with en=0: no load until en is seen high.
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    expect_val("post_rst_noload_v", 8'h00); pop_check({7'b0, b_vld});
    expect_val("post_rst_noload_q", 8'h00); pop_check(b_out_q);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    expect_val("post_rst_load", 8'h42); pop_check(b_out_q);
    en = 1'b0;

    // Unknown select propagates X (only observable on 4-state simulators).
    @(negedge clk);
    b1 = 8'h11; b3 = 8'h33;
    select1 = 1'b0; select0 = 1'bx;
    #1;
    if ($isunknown(select0)) begin
      expect_val("x_sel", 8'hxx); pop_check(b_out);
    end
    select0 = 1'b0;
    #0;
    #1 expect_val("x_restore_s1_0", 8'h11); pop_check(b_out);
    select1 = 1'b1;
    #1 expect_val("x_restore_s1_1", 8'h33); pop_check(b_out);

    if (exp_q.size() != 0) check("scoreboard_leftover", 8'(exp_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
